// File: rtl/tdc_meas_ctrl.sv
// Stop-measurement sequencer for the TDC: arms the stop synchronizer, counts
// coarse cycles until the synchronized stop rises, and hands the result to readout.
module tdc_meas_ctrl #(
    parameter int CNT_W   = 12,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 4000
) (
    input  logic             sync_clk_i,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             phase_s,
    input  logic             sync,
    output logic             s_sel,
    output logic             busy,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] coarse_cnt,
    output logic             timeout,
    output logic [2:0]       state_dbg
);

    // Handshake: once meas_valid rises, coarse_cnt/timeout stay frozen until an
    // edge samples meas_valid && meas_ready; meas_valid drops at that same edge.

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0]    TMO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETTLE_S = 3'd1,
        ARM_WAIT = 3'd2,
        COUNT    = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       scnt_q, scnt_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] coarse_q, coarse_d;
    logic             s_sel_q, s_sel_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    always_ff @(posedge sync_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            scnt_q    <= '0;
            tcnt_q    <= '0;
            cnt_q     <= '0;
            coarse_q  <= '0;
            s_sel_q   <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            scnt_q    <= scnt_d;
            tcnt_q    <= tcnt_d;
            cnt_q     <= cnt_d;
            coarse_q  <= coarse_d;
            s_sel_q   <= s_sel_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        scnt_d    = scnt_q;
        tcnt_d    = tcnt_q;
        cnt_d     = cnt_q;
        coarse_d  = coarse_q;
        s_sel_d   = s_sel_q;
        timeout_d = timeout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE_S;
                    s_sel_d = phase_s;
                    scnt_d  = '0;
                end
            end
            SETTLE_S: begin
                scnt_d = scnt_q + 4'd1;
                if (abort) begin
                    state_d = IDLE;
                end else if (scnt_q == SETTLE_LAST) begin
                    state_d = ARM_WAIT;
                    tcnt_d  = '0;
                    cnt_d   = '0;
                end
            end
            ARM_WAIT: begin
                // A high sync here is a stale stop, never a valid edge.
                tcnt_d = tcnt_q + TW'(1);
                if (abort) begin
                    state_d = IDLE;
                end else if (tcnt_q == TMO_LAST) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                    coarse_d  = cnt_q;
                end else if (!sync) begin
                    state_d = COUNT;
                    cnt_d   = '0;
                end
            end
            COUNT: begin
                tcnt_d = tcnt_q + TW'(1);
                if (abort) begin
                    state_d = IDLE;
                end else if (sync) begin
                    state_d   = DONE;
                    timeout_d = 1'b0;
                    coarse_d  = cnt_q;
                end else if (tcnt_q == TMO_LAST) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                    coarse_d  = cnt_q;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (meas_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d != IDLE);
        valid_d = (state_d == DONE);
    end

    assign s_sel      = s_sel_q;
    assign busy       = busy_q;
    assign meas_valid = valid_q;
    assign coarse_cnt = coarse_q;
    assign timeout    = timeout_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for tdc_meas_ctrl: expected {timeout, coarse_cnt} results are
// queued when the stop stimulus is driven and compared when meas_valid appears.
module tb_tdc_meas_ctrl;

    localparam int CNT_W   = 8;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 16;
    localparam int W       = CNT_W + 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETL  = 3'd1;
    localparam logic [2:0] ST_ARM   = 3'd2;
    localparam logic [2:0] ST_COUNT = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic             sync_clk_i = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic             phase_s;
    logic             sync;
    logic             meas_ready;
    logic             s_sel;
    logic             busy;
    logic             meas_valid;
    logic [CNT_W-1:0] coarse_cnt;
    logic             timeout;
    logic [2:0]       state_dbg;

    int n_assert = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    tdc_meas_ctrl #(.CNT_W(CNT_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .sync_clk_i (sync_clk_i),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .phase_s    (phase_s),
        .sync       (sync),
        .s_sel      (s_sel),
        .busy       (busy),
        .meas_valid (meas_valid),
        .meas_ready (meas_ready),
        .coarse_cnt (coarse_cnt),
        .timeout    (timeout),
        .state_dbg  (state_dbg)
    );

    // Clock / reset block
    always #5 sync_clk_i = ~sync_clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge sync_clk_i);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic do_start(input logic p, input logic with_abort);
        start   = 1'b1;
        phase_s = p;
        abort   = with_abort;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("busy_rise", busy, 1);
        chk("s_sel_load", s_sel, p);
        chk("state_settle", state_dbg, ST_SETL);
    endtask

    task automatic to_arm();
        tick();
        chk("settle_hold", state_dbg, ST_SETL);
        tick();
        chk("arm_entry", state_dbg, ST_ARM);
    endtask

    task automatic enter_count();
        tick();
        chk("count_entry", state_dbg, ST_COUNT);
    endtask

    task automatic wait_valid(input int budget, output int cycles);
        cycles = 0;
        while (!meas_valid && cycles < budget) begin
            tick();
            cycles++;
        end
        chk("valid_seen", meas_valid, 1);
    endtask

    // Stop first sampled at the k-th edge after COUNT entry.
    task automatic stop_at(input int k);
        int c;
        repeat (k - 1) tick();
        sync = 1'b1;
        exp_q.push_back({1'b0, CNT_W'(k - 1)});
        wait_valid(8, c);
        chk("stop_latency", c, 1);
        sync = 1'b0;
    endtask

    // Scoreboard compare
    task automatic check_result();
        logic [W-1:0] e;
        chk("sb_level", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("result", {timeout, coarse_cnt}, e);
        end
    endtask

    task automatic handshake();
        meas_ready = 1'b1;
        tick();
        meas_ready = 1'b0;
        chk("valid_drop", meas_valid, 0);
        chk("busy_drop", busy, 0);
        chk("back_idle", state_dbg, ST_IDLE);
    endtask

    initial begin
        int c;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; phase_s = 1'b0;
        sync = 1'b0; meas_ready = 1'b0;
        repeat (2) tick();
        chk("rst_s_sel", s_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", meas_valid, 0);
        chk("rst_coarse", coarse_cnt, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_state", state_dbg, ST_IDLE);
        rst_n = 1'b1;
        tick();

        // Normal stop at the 6th edge after COUNT entry, phase 1
        do_start(1'b1, 1'b0);
        to_arm();
        enter_count();
        stop_at(6);
        check_result();
        chk("t1_s_sel", s_sel, 1);
        handshake();

        // Back-to-back start, then DONE held with start/abort pulses
        do_start(1'b1, 1'b0);
        to_arm();
        enter_count();
        stop_at(2);
        check_result();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin start = 1'b1; phase_s = 1'b0; end
            if (i == 6) abort = 1'b1;
            tick();
            start = 1'b0;
            abort = 1'b0;
            chk("hold_valid", meas_valid, 1);
            chk("hold_coarse", coarse_cnt, 1);
            chk("hold_timeout", timeout, 0);
            chk("hold_state", state_dbg, ST_DONE);
            chk("hold_s_sel", s_sel, 1);
        end
        handshake();
        repeat (2) begin
            tick();
            chk("no_queued_start", busy, 0);
        end

        // No stop at all: timeout result after TIMEOUT cycles from ARM_WAIT
        do_start(1'b0, 1'b0);
        to_arm();
        exp_q.push_back({1'b1, CNT_W'(TIMEOUT - 2)});
        wait_valid(40, c);
        chk("tmo_latency", c, TIMEOUT);
        check_result();
        handshake();

        // Stale stop never clears: timeout out of ARM_WAIT with count 0
        sync = 1'b1;
        do_start(1'b1, 1'b0);
        to_arm();
        exp_q.push_back({1'b1, CNT_W'(0)});
        wait_valid(40, c);
        chk("arm_tmo_latency", c, TIMEOUT);
        check_result();
        sync = 1'b0;
        handshake();

        // Stop edge on the same cycle as the timeout: edge wins
        do_start(1'b0, 1'b0);
        to_arm();
        repeat (TIMEOUT - 1) tick();
        sync = 1'b1;
        exp_q.push_back({1'b0, CNT_W'(TIMEOUT - 2)});
        wait_valid(8, c);
        chk("edge_vs_tmo_latency", c, 1);
        check_result();
        sync = 1'b0;
        handshake();

        // Stale stop for 4 samples, then low, then stop three edges later
        sync = 1'b1;
        do_start(1'b1, 1'b0);
        to_arm();
        repeat (4) begin
            tick();
            chk("stale_hold", state_dbg, ST_ARM);
        end
        sync = 1'b0;
        enter_count();
        stop_at(3);
        check_result();
        handshake();

        // Abort in COUNT at cnt=3
        do_start(1'b1, 1'b0);
        to_arm();
        enter_count();
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", state_dbg, ST_IDLE);
        chk("abort_busy", busy, 0);
        chk("abort_s_sel", s_sel, 1);
        repeat (3) begin
            tick();
            chk("abort_no_valid", meas_valid, 0);
        end

        // Abort in SETTLE
        do_start(1'b1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("settle_abort_idle", state_dbg, ST_IDLE);
        chk("settle_abort_valid", meas_valid, 0);

        // start+abort together in IDLE: start wins, phase 0
        do_start(1'b0, 1'b1);
        to_arm();
        enter_count();
        stop_at(4);
        check_result();
        chk("t5_s_sel", s_sel, 0);
        handshake();

        // Reset while a result is pending
        do_start(1'b1, 1'b0);
        to_arm();
        enter_count();
        stop_at(1);
        check_result();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", meas_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_s_sel", s_sel, 0);
        chk("arst_coarse", coarse_cnt, 0);
        chk("arst_timeout", timeout, 0);
        chk("arst_state", state_dbg, ST_IDLE);
        tick();
        rst_n = 1'b1;
        tick();
        do_start(1'b1, 1'b0);
        to_arm();
        enter_count();
        stop_at(5);
        check_result();
        handshake();

        chk("sb_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tdc_meas_ctrl.md
# tdc_meas_ctrl

Sequencer for one TDC stop measurement on the inverted-clk5 domain. It arms the stop-synchronizer path and drives its edge-select line (`s_sel`) from the fine-phase decision. It counts coarse cycles until the synchronized stop (`sync`) rises, then hands the coarse count to readout over a valid/ready handshake. Timeout and abort handling ensure a missing stop never hangs the measurement chain.

## Interface
- `CNT_W`, default 12: coarse counter width.
- `SETTLE`, default 2: cycles to wait after changing `s_sel` before sampling `sync`; legal range 1..15.
- `TIMEOUT`, default 4000: maximum cycles from the end of settle to the stop edge; must be ≥2.

Ports:
- `sync_clk_i`, in, 1: clock (inverted clk5), rising-edge active.
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `start`, in, 1: single-cycle arm request; honoured only in IDLE.
- `abort`, in, 1: cancel the measurement in progress.
- `phase_s`, in, 1: stop-edge phase select, sampled with `start`.
- `sync`, in, 1: synchronized stop from the stop synchronizer.
- `s_sel`, out, 1: phase select to the stop synchronizer's mux.
- `busy`, out, 1: high in every state except IDLE.
- `meas_valid`, out, 1: result available.
- `meas_ready`, in, 1: readout accepts the result.
- `coarse_cnt`, out, CNT_W: coarse cycle count.
- `timeout`, out, 1: result is a timeout; qualified by `meas_valid`.

## Operation
States and transitions:
- **IDLE**
  - On `start`=1: `s_sel` <= `phase_s`; settle counter <= 0; go to SETTLE.
- **SETTLE**
  - Settle counter increments each cycle.
  - After SETTLE cycles in this state: go to ARM_WAIT; timeout counter <= 0.
- **ARM_WAIT**
  - Waits for `sync`=0, i.e. the stale stop is flushed.
  - On `sync`=0: go to COUNT; `cnt` <= 0.
  - Otherwise stay.
- **COUNT**
  - On `sync`=1: `coarse_cnt` <= `cnt`; `timeout` <= 0; go to DONE.
  - Otherwise `cnt` <= `cnt`+1, saturating at 2^CNT_W−1 (no wrap).
- **DONE**
  - `meas_valid`=1.
  - `coarse_cnt` and `timeout` held stable until accepted.
  - When `meas_valid`&`meas_ready` at an edge: go to IDLE; `meas_valid` deasserts at that edge.

Timeout counter:
- Increments every cycle in ARM_WAIT and COUNT.
- When it equals TIMEOUT−1 and no stop edge is sampled that cycle: go to DONE with `timeout`=1 and `coarse_cnt` <= current `cnt`. From ARM_WAIT, `cnt` is 0.

Boundary rules:
- A stop edge and timeout in the same cycle: the edge wins, `timeout`=0.
- `abort` in SETTLE, ARM_WAIT or COUNT: go to IDLE next edge with no result. `s_sel` keeps its value.
- `abort` in DONE or IDLE: ignored. A produced result must be consumed.
- `start` while `busy`: ignored, not queued.
- `start`+`abort` together in IDLE: `start` wins.
- `s_sel` changes only on the IDLE→SETTLE transition.
- `meas_valid` never drops without a handshake (except under reset).
- `rst_n` low at any time, including mid-measurement or with `meas_valid` high: all state clears immediately; the result is lost.

## Timing
- Reset values:
  - `s_sel`=0, `busy`=0, `meas_valid`=0, `coarse_cnt`=0, `timeout`=0.
  - State IDLE; all internal counters 0.
- All outputs are registered; no combinational input→output path.
- `busy` rises one cycle after `start` is sampled.
- ARM_WAIT is entered SETTLE cycles after `busy` rises.
- Stop sampled at edge k after COUNT entry (k≥1): `coarse_cnt`=k−1, and `meas_valid` is high after that same edge.
- Back-to-back: `start` can be accepted in the first cycle back in IDLE, one cycle after the handshake.

## Test plan
1. SETTLE=2, TIMEOUT=16, CNT_W=8; `phase_s`=1, `start` pulse, `sync`=0, `sync` first sampled high at the 6th edge after COUNT entry -> `s_sel`=1, `coarse_cnt`=5, `timeout`=0, `meas_valid`=1.
2. Same parameters, `sync` never rises -> `meas_valid` 16 cycles after ARM_WAIT entry, `timeout`=1, `coarse_cnt`=14.
3. `sync` held 1 for 4 cycles after settle, then 0, then 1 three edges later -> stays in ARM_WAIT 4 cycles, `coarse_cnt`=2.
4. `meas_ready`=0 for 10 cycles in DONE, with `start` and `abort` pulsed meanwhile -> `meas_valid`/`coarse_cnt` stable, both pulses ignored; `meas_ready`=1 -> IDLE next edge.
5. `abort` in COUNT at `cnt`=3 -> IDLE next edge, no `meas_valid`. A new `start` with `phase_s`=0 -> `s_sel`=0 and a normal measurement.
6. `rst_n` low while `meas_valid`=1 -> all outputs 0 immediately; normal measurement after release.
